// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a Moore/Mealy FSM that sequences datapath
// controls per instruction class, with memory-ready stalls, retire counting and illegal-opcode halt.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        retire,
    output logic [15:0] instr_count,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            count_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (retire)
                count_reg <= count_reg + 16'd1;
        end
    end

    always_comb begin
        state_next  = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        retire      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEM_ADDR;
                else if (opcode == OP_RTYPE)            state_next = S_R_EXEC;
                else if (opcode == OP_BEQ)              state_next = S_BRANCH;
                else if (opcode == OP_J)                state_next = S_JUMP;
                else if (opcode == OP_ADDI)             state_next = S_ADDI_EXEC;
                else                                    state_next = S_HALT;
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                retire     = mem_ready;
                state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_R_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                state_next = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
            S_ADDI_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // Reset squashes any side effect the current state would otherwise commit.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            retire      = 1'b0;
        end
    end

    assign state       = state_reg;
    assign instr_count = count_reg;
    assign halted      = (state_reg == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench: each instruction is expanded into its expected per-cycle trace,
// which drives the inputs and is checked cycle by cycle, plus hand-computed literal checks.
module tb_multicycle_control;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;
    localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MWR = 4'd5;
    localparam logic [3:0] RX = 4'd6, RWB = 4'd7, BR = 4'd8, JP = 4'd9, AX = 4'd10, AWB = 4'd11, HL = 4'd12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic retire, halted;
    logic [15:0] instr_count;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .retire(retire), .instr_count(instr_count),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  st;
        logic        chk;
        logic [15:0] ctrl;
        logic        ret;
    } exp_t;

    exp_t        cur;
    logic        cur_valid = 1'b0;
    logic [15:0] model_count = 16'd0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] act_ctrl;

    assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table straight from the per-state rules; fields not named stay 0.
    function automatic logic [15:0] ctrl_for(input logic [3:0] st, input logic mr);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = 10'd0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            FE:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            DE:  asb = 2'b11;
            MA:  begin asa = 1; asb = 2'b10; end
            MR:  begin mrd = 1; iord = 1; end
            MWB: begin rw = 1; m2r = 1; end
            MWR: begin mwr = 1; iord = 1; end
            RX:  begin asa = 1; aop = 2'b10; end
            RWB: begin rw = 1; rdst = 1; end
            BR:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            JP:  begin pcw = 1; pcs = 2'b10; end
            AX:  begin asa = 1; asb = 2'b10; end
            AWB: rw = 1;
            default: ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
    endfunction

    function automatic logic retire_for(input logic [3:0] st, input logic mr);
        return (st == MWB || st == RWB || st == BR || st == JP || st == AWB) || (st == MWR && mr);
    endfunction

    // Drive one cycle's inputs and publish its expectation; returns 3 time units later.
    task automatic add(input logic r, input logic [3:0] st, input logic mr, input logic [5:0] op, input logic chk);
        @(negedge clk);
        rst = r; mem_ready = mr; opcode = op;
        cur.rst  = r;
        cur.st   = st;
        cur.chk  = chk;
        cur.ctrl = r ? 16'd0 : ctrl_for(st, mr);
        cur.ret  = r ? 1'b0 : retire_for(st, mr);
        cur_valid = 1'b1;
        #3;
    endtask

    // States where opcode and (mostly) mem_ready must not matter get random values.
    task automatic step(input logic [3:0] st, input logic mr);
        add(1'b0, st, mr, 6'($urandom), 1'b1);
    endtask

    task automatic step_any(input logic [3:0] st);
        add(1'b0, st, 1'($urandom), 6'($urandom), 1'b1);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall);
        for (int i = 0; i < fstall; i++) step(FE, 1'b0);
        step(FE, 1'b1);
        add(1'b0, DE, 1'($urandom), op, 1'b1);
        case (op)
            LW: begin
                add(1'b0, MA, 1'($urandom), op, 1'b1);
                for (int i = 0; i < mstall; i++) step(MR, 1'b0);
                step(MR, 1'b1);
                step_any(MWB);
            end
            SW: begin
                add(1'b0, MA, 1'($urandom), op, 1'b1);
                for (int i = 0; i < mstall; i++) step(MWR, 1'b0);
                step(MWR, 1'b1);
            end
            RT:   begin step_any(RX); step_any(RWB); end
            BEQ:  step_any(BR);
            JMP:  step_any(JP);
            ADDI: begin step_any(AX); step_any(AWB); end
            default: step_any(HL);
        endcase
    endtask

    // Single compare process: every driven cycle is checked against its expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cur_valid) begin
                cur_valid = 1'b0;
                check("ctrl", 32'(act_ctrl), 32'(cur.ctrl));
                check("retire", 32'(retire), 32'(cur.ret));
                if (cur.chk) begin
                    check("state", 32'(state), 32'(cur.st));
                    check("instr_count", 32'(instr_count), 32'(model_count));
                    if (!cur.rst) check("halted", 32'(halted), 32'(cur.st == HL));
                end
                if (cur.rst) model_count = 16'd0;
                else if (cur.ret) model_count = model_count + 16'd1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] held_count;

    initial begin
        // Reset from power-up, then FETCH outputs in the first cycle afterwards.
        add(1'b1, FE, 1'b0, RT, 1'b0);
        add(1'b1, FE, 1'b1, RT, 1'b1);
        step(FE, 1'b1);
        check("lit_reset_state", 32'(state), 32'd0);
        check("lit_reset_count", 32'(instr_count), 32'd0);
        check("lit_fetch_memread", 32'(MemRead), 32'd1);
        check("lit_fetch_alusrcb", 32'(ALUSrcB), 32'b01);

        // R-type: 0,1,6,7 then back to FETCH with count 1.
        add(1'b0, DE, 1'b0, RT, 1'b1);
        step_any(RX);
        check("lit_rexec_aluop", 32'(ALUOp), 32'b10);
        step_any(RWB);
        check("lit_rwb_regwrite", 32'(RegWrite), 32'd1);
        check("lit_rwb_regdst", 32'(RegDst), 32'd1);

        // FETCH stalled 3 cycles, then LW with 2 stalled MEM_READ cycles.
        for (int i = 0; i < 3; i++) begin
            step(FE, 1'b0);
            check("lit_stall_irwrite", 32'(IRWrite), 32'd0);
        end
        check("lit_r_count", 32'(instr_count), 32'd1);
        step(FE, 1'b1);
        check("lit_fetch_irwrite", 32'(IRWrite), 32'd1);
        check("lit_fetch_pcwrite", 32'(PCWrite), 32'd1);
        add(1'b0, DE, 1'b1, LW, 1'b1);
        add(1'b0, MA, 1'b1, LW, 1'b1);
        step(MR, 1'b0);
        step(MR, 1'b0);
        step(MR, 1'b1);
        step_any(MWB);
        check("lit_memwb_memtoreg", 32'(MemtoReg), 32'd1);

        run_instr(SW, 0, 0);
        run_instr(SW, 2, 3);
        run_instr(ADDI, 1, 0);
        run_instr(BEQ, 0, 0);
        run_instr(JMP, 2, 0);
        run_instr(RT, 0, 0);

        // Counter wrap: preload just below the top during a FETCH stall.
        step(FE, 1'b0);
        force dut.count_reg = 16'hFFFE;
        model_count = 16'hFFFE;
        #1;
        release dut.count_reg;
        run_instr(JMP, 0, 0);
        step(FE, 1'b1);
        check("lit_wrap_ffff", 32'(instr_count), 32'hFFFF);
        add(1'b0, DE, 1'b1, BEQ, 1'b1);
        step_any(BR);
        check("lit_branch_pcwc", 32'(PCWriteCond), 32'd1);
        check("lit_branch_aluop", 32'(ALUOp), 32'b01);
        step(FE, 1'b0);
        check("lit_wrap_zero", 32'(instr_count), 32'd0);

        // Reset in MEM_WRITE with mem_ready high suppresses the store.
        step(FE, 1'b1);
        add(1'b0, DE, 1'b1, SW, 1'b1);
        add(1'b0, MA, 1'b1, SW, 1'b1);
        add(1'b1, MWR, 1'b1, 6'($urandom), 1'b1);
        check("lit_rst_memwrite", 32'(MemWrite), 32'd0);
        step(FE, 1'b0);
        check("lit_rst_count", 32'(instr_count), 32'd0);
        check("lit_rst_state", 32'(state), 32'd0);

        // Illegal opcode traps and holds until reset.
        run_instr(LW, 0, 1);
        step(FE, 1'b1);
        add(1'b0, DE, 1'b1, BAD, 1'b1);
        held_count = instr_count;
        for (int i = 0; i < 10; i++) begin
            step_any(HL);
            check("lit_halted", 32'(halted), 32'd1);
            check("lit_halt_count", 32'(instr_count), 32'(held_count));
        end
        add(1'b1, HL, 1'b1, 6'($urandom), 1'b1);
        step(FE, 1'b0);
        check("lit_unhalt", 32'(halted), 32'd0);
        run_instr(ADDI, 0, 0);
        run_instr(RT, 1, 0);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
